// File: rtl/bram_multibank_req_wrap.sv
// Request/grant front end for NUM_BANKS word-interleaved BRAM ports with an in-order response FIFO.
// Loads and stores both answer; outstanding requests are capped by a credit counter sized to the FIFO.
module bram_multibank_req_wrap #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_BANKS  = 2,
    parameter int RD_LATENCY = 1,
    parameter int RESP_DEPTH = 4,
    localparam int BSEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    localparam int BANK_AW   = ADDR_WIDTH - BSEL_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            data_req_i,
    input  logic [ADDR_WIDTH-1:0]           data_add_i,
    input  logic                            data_wen_i,
    input  logic [DATA_WIDTH-1:0]           data_wdata_i,
    input  logic [BE_WIDTH-1:0]             data_be_i,
    output logic                            data_gnt_o,
    output logic                            data_r_valid_o,
    output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
    input  logic                            data_r_ready_i,
    output logic [NUM_BANKS-1:0]            ENA_o,
    output logic [NUM_BANKS*BE_WIDTH-1:0]   WEA_o,
    output logic [NUM_BANKS*BANK_AW-1:0]    ADDRA_o,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] DINA_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] DOUTA_i
);

    localparam int BIDX_W = (BSEL_W > 0) ? BSEL_W : 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

    logic                  w_gnt;
    logic [BIDX_W-1:0]     w_bank;
    logic [BANK_AW-1:0]    w_bank_addr;
    logic [NUM_BANKS-1:0]  w_sel;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_push_data;

    logic [CNT_W-1:0]                   r_outstanding;
    logic [RD_LATENCY-1:0]              r_pipe_valid;
    logic [RD_LATENCY-1:0]              r_pipe_load;
    logic [RD_LATENCY-1:0][BIDX_W-1:0]  r_pipe_bank;
    logic [DATA_WIDTH-1:0]              r_fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]                   r_wr_ptr;
    logic [PTR_W-1:0]                   r_rd_ptr;
    logic [CNT_W-1:0]                   r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    generate
        if (NUM_BANKS > 1) begin : g_bsel
            assign w_bank      = data_add_i[BSEL_W-1:0];
            assign w_bank_addr = data_add_i[ADDR_WIDTH-1:BSEL_W];
        end else begin : g_nobsel
            assign w_bank      = '0;
            assign w_bank_addr = data_add_i;
        end
    endgenerate

    // Credit covers pipeline plus FIFO, so a granted request always has a FIFO slot waiting.
    assign w_gnt      = data_req_i & ~rst & (r_outstanding < CNT_W'(RESP_DEPTH));
    assign data_gnt_o = w_gnt;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign w_sel[gi]  = w_gnt & (w_bank == BIDX_W'(gi));
            assign ENA_o[gi]  = w_sel[gi];
            assign WEA_o[gi*BE_WIDTH +: BE_WIDTH]       = (w_sel[gi] & ~data_wen_i) ? data_be_i : '0;
            assign ADDRA_o[gi*BANK_AW +: BANK_AW]       = w_sel[gi] ? w_bank_addr : '0;
            assign DINA_o[gi*DATA_WIDTH +: DATA_WIDTH]  = w_sel[gi] ? data_wdata_i : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_valid <= '0;
            r_pipe_load  <= '0;
            r_pipe_bank  <= '0;
        end else begin
            r_pipe_valid[0] <= w_gnt;
            r_pipe_load[0]  <= data_wen_i;
            r_pipe_bank[0]  <= w_bank;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_load[i]  <= r_pipe_load[i-1];
                r_pipe_bank[i]  <= r_pipe_bank[i-1];
            end
        end
    end

    // The last stage lines up with DOUTA of the bank that was addressed RD_LATENCY edges ago.
    assign w_push = r_pipe_valid[RD_LATENCY-1];

    always_comb begin
        w_push_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_pipe_load[RD_LATENCY-1] && (r_pipe_bank[RD_LATENCY-1] == BIDX_W'(b))) begin
                w_push_data = DOUTA_i[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & data_r_ready_i;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_gnt && !w_pop) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_gnt && w_pop) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
        end
    end

    assign data_r_valid_o = w_valid;
    assign data_r_rdata_o = w_valid ? r_fifo_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_bram_multibank_req_wrap.sv
// Directed bench: a 2-bank/latency-1 instance and a 4-bank/latency-3 instance, each with a BRAM model.
module tb_bram_multibank_req_wrap;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // instance A: 2 banks, latency 1, depth 4
    logic         rst_a, req_a, wen_a, gnt_a, rv_a, rdy_a;
    logic [9:0]   add_a;
    logic [31:0]  wdata_a, rdata_a;
    logic [3:0]   be_a;
    logic [1:0]   ena_a;
    logic [7:0]   wea_a;
    logic [17:0]  addra_a;
    logic [63:0]  dina_a, douta_a;

    // instance B: 4 banks, latency 3, depth 5
    logic         rst_b, req_b, wen_b, gnt_b, rv_b, rdy_b;
    logic [9:0]   add_b;
    logic [31:0]  wdata_b, rdata_b;
    logic [3:0]   be_b;
    logic [3:0]   ena_b;
    logic [15:0]  wea_b;
    logic [31:0]  addra_b;
    logic [127:0] dina_b, douta_b;

    bram_multibank_req_wrap u_dut_a (
        .clk(clk), .rst(rst_a), .data_req_i(req_a), .data_add_i(add_a), .data_wen_i(wen_a),
        .data_wdata_i(wdata_a), .data_be_i(be_a), .data_gnt_o(gnt_a), .data_r_valid_o(rv_a),
        .data_r_rdata_o(rdata_a), .data_r_ready_i(rdy_a), .ENA_o(ena_a), .WEA_o(wea_a),
        .ADDRA_o(addra_a), .DINA_o(dina_a), .DOUTA_i(douta_a)
    );

    bram_multibank_req_wrap #(.NUM_BANKS(4), .RD_LATENCY(3), .RESP_DEPTH(5)) u_dut_b (
        .clk(clk), .rst(rst_b), .data_req_i(req_b), .data_add_i(add_b), .data_wen_i(wen_b),
        .data_wdata_i(wdata_b), .data_be_i(be_b), .data_gnt_o(gnt_b), .data_r_valid_o(rv_b),
        .data_r_rdata_o(rdata_b), .data_r_ready_i(rdy_b), .ENA_o(ena_b), .WEA_o(wea_b),
        .ADDRA_o(addra_b), .DINA_o(dina_b), .DOUTA_i(douta_b)
    );

    // BRAM models: read-first, byte writes, output pipeline of the configured latency
    logic [31:0] mem_a [2][512];
    logic [31:0] dq_a  [2];
    logic [31:0] mem_b [4][256];
    logic [31:0] dq_b  [4][3];

    always @(posedge clk) begin
        for (int bk = 0; bk < 2; bk++) begin
            if (ena_a[bk]) begin
                dq_a[bk] <= mem_a[bk][addra_a[bk*9 +: 9]];
                for (int k = 0; k < 4; k++)
                    if (wea_a[bk*4+k]) mem_a[bk][addra_a[bk*9 +: 9]][k*8 +: 8] <= dina_a[bk*32+k*8 +: 8];
            end
        end
        for (int bk = 0; bk < 4; bk++) begin
            if (ena_b[bk]) begin
                dq_b[bk][0] <= mem_b[bk][addra_b[bk*8 +: 8]];
                for (int k = 0; k < 4; k++)
                    if (wea_b[bk*4+k]) mem_b[bk][addra_b[bk*8 +: 8]][k*8 +: 8] <= dina_b[bk*32+k*8 +: 8];
            end
            dq_b[bk][1] <= dq_b[bk][0];
            dq_b[bk][2] <= dq_b[bk][1];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_da
            assign douta_a[gi*32 +: 32] = dq_a[gi];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_db
            assign douta_b[gi*32 +: 32] = dq_b[gi][2];
        end
    endgenerate

    // response / grant logging
    logic [31:0] resp_a[$], resp_b[$];
    int gcyc_a[$], rcyc_a[$], gcyc_b[$], rcyc_b[$];

    always @(negedge clk) begin
        if (!rst_a) begin
            if (gnt_a) gcyc_a.push_back(cyc);
            if (rv_a && rdy_a) begin resp_a.push_back(rdata_a); rcyc_a.push_back(cyc); end
        end
        if (!rst_b) begin
            if (gnt_b) gcyc_b.push_back(cyc);
            if (rv_b && rdy_b) begin resp_b.push_back(rdata_b); rcyc_b.push_back(cyc); end
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        resp_a.delete(); rcyc_a.delete(); gcyc_a.delete();
        resp_b.delete(); rcyc_b.delete(); gcyc_b.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge with req dropped.
    task automatic issue(input bit b, input bit ld, input int addr, input logic [31:0] wd,
                         input logic [3:0] be, output int waited);
        int nb, baw, bank, baddr;
        logic [127:0] e_ena, e_wea, e_addr, e_din;
        nb    = b ? 4 : 2;
        baw   = b ? 8 : 9;
        bank  = addr % nb;
        baddr = addr / nb;
        e_ena  = 128'(1) << bank;
        e_wea  = ld ? 128'(0) : (128'(be) << (bank * 4));
        e_addr = 128'(baddr) << (bank * baw);
        e_din  = 128'(wd) << (bank * 32);
        if (!b) begin req_a = 1; add_a = addr[9:0]; wen_a = ld; wdata_a = wd; be_a = be; end
        else    begin req_b = 1; add_b = addr[9:0]; wen_b = ld; wdata_b = wd; be_b = be; end
        waited = 0;
        forever begin
            @(negedge clk);
            if (b ? gnt_b : gnt_a) break;
            waited++;
            if (waited > 40) break;
            @(posedge clk); #1;
        end
        if (waited > 40) begin
            check_val("gnt_timeout", 128'(waited), 128'(0));
        end else begin
            check_val("ena",   b ? 128'(ena_b)   : 128'(ena_a),   e_ena);
            check_val("wea",   b ? 128'(wea_b)   : 128'(wea_a),   e_wea);
            check_val("addra", b ? 128'(addra_b) : 128'(addra_a), e_addr);
            check_val("dina",  b ? 128'(dina_b)  : 128'(dina_a),  e_din);
            $display("tx dut=%s %s addr=%0d wdata=%h be=%h wait=%0d cyc=%0d",
                     b ? "B" : "A", ld ? "LD" : "ST", addr, wd, be, waited, cyc);
        end
        @(posedge clk); #1;
        if (!b) req_a = 0; else req_b = 0;
    endtask

    task automatic wait_resp(input bit b, input int n);
        int k = 0;
        while (((b ? resp_b.size() : resp_a.size()) < n) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) check_val("resp_timeout", 128'(b ? resp_b.size() : resp_a.size()), 128'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int bk = 0; bk < 2; bk++) for (int i = 0; i < 512; i++) mem_a[bk][i] = '0;
        for (int bk = 0; bk < 4; bk++) for (int i = 0; i < 256; i++) mem_b[bk][i] = '0;
        for (int bk = 0; bk < 2; bk++) dq_a[bk] = '0;
        for (int bk = 0; bk < 4; bk++) for (int i = 0; i < 3; i++) dq_b[bk][i] = '0;

        // reset with a request pending: everything must stay 0
        rst_a = 1; rst_b = 1; rdy_a = 1; rdy_b = 1;
        req_a = 1; add_a = 10'd5; wen_a = 1; wdata_a = '0; be_a = '0;
        req_b = 1; add_b = 10'd5; wen_b = 1; wdata_b = '0; be_b = '0;
        #12;
        check_val("rst_gnt_a",   gnt_a,   0);
        check_val("rst_rv_a",    rv_a,    0);
        check_val("rst_ena_a",   ena_a,   0);
        check_val("rst_rdata_a", rdata_a, 0);
        check_val("rst_gnt_b",   gnt_b,   0);
        check_val("rst_ena_b",   ena_b,   0);
        @(posedge clk); #1;
        req_a = 0; req_b = 0; rst_a = 0; rst_b = 0;
        @(posedge clk); #1;

        // 1: stores 0..15, no gaps, zero rdata on store responses
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            issue(0, 0, i, 32'(i), 4'hF, w);
            check_val("t1_nogap", 128'(w), 0);
        end
        wait_resp(0, 16);
        for (int i = 0; i < 16 && i < resp_a.size(); i++) check_val("t1_rdata", resp_a[i], 0);

        // 2: loads 0..15 back to back, latency 2
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            issue(0, 1, i, 32'h0, 4'h0, w);
            check_val("t2_nogap", 128'(w), 0);
        end
        wait_resp(0, 16);
        for (int i = 0; i < 16 && i < resp_a.size(); i++) check_val("t2_rdata", resp_a[i], 128'(i));
        if (rcyc_a.size() > 0 && gcyc_a.size() > 0)
            check_val("t2_latency", 128'(rcyc_a[0] - gcyc_a[0]), 128'(2));

        // 3: byte-enable merge, store then load same address on consecutive grants
        clear_logs();
        issue(0, 0, 3, 32'hAABBCCDD, 4'hF, w);
        issue(0, 0, 3, 32'h11223344, 4'b0101, w);
        issue(0, 1, 3, 32'h0, 4'h0, w);
        wait_resp(0, 3);
        if (resp_a.size() >= 3) begin
            check_val("t3_st0", resp_a[0], 0);
            check_val("t3_st1", resp_a[1], 0);
            check_val("t3_merge", resp_a[2], 128'h00000000AA22CC44);
        end

        // 4: backpressure fills the credit window
        clear_logs();
        rdy_a = 0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 1, 8 + i, 32'h0, 4'h0, w);
            check_val("t4_nogap", 128'(w), 0);
        end
        req_a = 1; add_a = 10'd12; wen_a = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("t4_gnt_blocked", gnt_a, 0);
            check_val("t4_rv_held", rv_a, 1);
            check_val("t4_rdata_held", rdata_a, 8);
            @(posedge clk); #1;
        end
        rdy_a = 1;
        issue(0, 1, 12, 32'h0, 4'h0, w);
        issue(0, 1, 13, 32'h0, 4'h0, w);
        wait_resp(0, 6);
        for (int i = 0; i < 6 && i < resp_a.size(); i++) check_val("t4_order", resp_a[i], 128'(8 + i));

        // 5: reset with three loads in flight
        clear_logs();
        rdy_a = 0;
        for (int i = 0; i < 3; i++) issue(0, 1, 4 + i, 32'h0, 4'h0, w);
        req_a = 1; add_a = 10'd7; wen_a = 1;
        rst_a = 1;
        #2;
        check_val("t5_gnt", gnt_a, 0);
        check_val("t5_rv",  rv_a,  0);
        check_val("t5_ena", ena_a, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_a = 0; req_a = 0; rdy_a = 1;
        for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
        check_val("t5_no_stale", 128'(resp_a.size()), 0);
        check_val("t5_rv_idle", rv_a, 0);
        for (int i = 0; i < 3; i++) issue(0, 1, 4 + i, 32'h0, 4'h0, w);
        wait_resp(0, 3);
        for (int i = 0; i < 3 && i < resp_a.size(); i++) check_val("t5_reload", resp_a[i], 128'(4 + i));

        // 6: 4 banks, latency 3, depth 5
        clear_logs();
        for (int i = 0; i < 32; i++) begin
            issue(1, 0, i, 32'h100 + 32'(i), 4'hF, w);
            check_val("t6_st_nogap", 128'(w), 0);
        end
        wait_resp(1, 32);
        for (int i = 0; i < 32 && i < resp_b.size(); i++) check_val("t6_st_rdata", resp_b[i], 0);
        clear_logs();
        for (int i = 0; i < 32; i++) begin
            issue(1, 1, i, 32'h0, 4'h0, w);
            check_val("t6_ld_nogap", 128'(w), 0);
        end
        wait_resp(1, 32);
        for (int i = 0; i < 32 && i < resp_b.size(); i++) begin
            check_val("t6_ld_rdata", resp_b[i], 128'(32'h100 + 32'(i)));
            if (i < gcyc_b.size() && i < rcyc_b.size())
                check_val("t6_latency", 128'(rcyc_b[i] - gcyc_b[i]), 128'(4));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
